// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default geometry and
// the frame-level bit values that the transmitter also uses.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned UART_OVS    = 16;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input. The reset value is
// a parameter so an idle-high line does not look like activity out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop decoding of a synchronised rx
// line, with a valid/ready output register, framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W,
  parameter int unsigned OVS    = UART_OVS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic              rx_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              frame_err_o,
  output logic              overrun_o,
  output logic              busy_o
);

  localparam int unsigned   TW      = $clog2(OVS);
  localparam int unsigned   BW      = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] TC_MID  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TC_LAST = TW'(OVS - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(DATA_W - 1);

  logic              w_rx_s;
  rx_state_t         r_state;
  rx_state_t         w_state_nxt;
  logic [TW-1:0]     r_tcnt;
  logic [TW-1:0]     w_tcnt_nxt;
  logic [BW-1:0]     r_bcnt;
  logic [BW-1:0]     w_bcnt_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_frame_err;
  logic              r_overrun;
  logic              w_done;
  logic              w_ferr;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (rx_i),
    .q_o  (w_rx_s)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, counter and shift-register decode; w_done/w_ferr mark the
  // stop-bit sampling cycle. Data bits shift in from the top so that after
  // DATA_W samples the first (LSB) bit has arrived at bit 0.
  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_bcnt_nxt  = r_bcnt;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rx_s == START_BIT) begin
          w_tcnt_nxt  = '0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (tick_i) begin
          if (r_tcnt == TC_MID) begin
            if (w_rx_s == START_BIT) begin
              w_tcnt_nxt  = '0;
              w_bcnt_nxt  = '0;
              w_state_nxt = DATA;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_tcnt_nxt = r_tcnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (tick_i) begin
          if (r_tcnt == TC_LAST) begin
            w_tcnt_nxt  = '0;
            w_shift_nxt = {w_rx_s, r_shift[DATA_W-1:1]};
            w_bcnt_nxt  = r_bcnt + BW'(1);
            if (r_bcnt == BC_LAST) begin
              w_state_nxt = STOP;
            end
          end else begin
            w_tcnt_nxt = r_tcnt + TW'(1);
          end
        end
      end
      STOP: begin
        if (tick_i) begin
          if (r_tcnt == TC_LAST) begin
            w_tcnt_nxt = '0;
            if (w_rx_s == STOP_BIT) begin
              w_done      = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_ferr      = 1'b1;
              w_state_nxt = WAIT_IDLE;
            end
          end else begin
            w_tcnt_nxt = r_tcnt + TW'(1);
          end
        end
      end
      WAIT_IDLE: begin
        if (w_rx_s == STOP_BIT) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Counter and shift-register storage.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_tcnt  <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
    end else begin
      r_tcnt  <= w_tcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Output holding register with valid/ready handshake and overrun detection.
  // A completing byte loads only if the slot is empty or being drained now.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= 1'b0;
      if (w_done) begin
        if (!r_valid || ready_i) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;
  assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with OVS=16 and tick_i tied high (1 bit = 16 clk).
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       ferr;
  logic       ovr;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int vrise_cnt = 0;
  logic prev_valid = 1'b0;

  uart_rx #(
    .DATA_W(8),
    .OVS   (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .tick_i     (tick),
    .rx_i       (rx),
    .data_o     (data),
    .valid_o    (valid),
    .ready_i    (ready),
    .frame_err_o(ferr),
    .overrun_o  (ovr),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse/edge counters sampled on the falling edge.
  always @(negedge clk) begin
    if (ferr) ferr_cnt++;
    if (ovr) ovr_cnt++;
    if (valid && !prev_valid) vrise_cnt++;
    prev_valid = valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    cyc(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(16);
    end
    rx = stop;
    cyc(16);
  endtask

  task automatic consume(input string tag);
    ready = 1'b1;
    cyc(1);
    check(tag, 32'(valid), 32'd0);
    ready = 1'b0;
  endtask

  int lat;
  int ferr_base;
  int ovr_base;
  int vrise_base;

  initial begin
    rst_n = 1'b0;
    tick  = 1'b1;
    rx    = 1'b1;
    ready = 1'b0;

    // Reset state
    cyc(3);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    cyc(5);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Single byte 0xA5 with latency measured from the start edge
    ferr_base = ferr_cnt;
    ovr_base  = ovr_cnt;
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!valid && lat < 200) begin
          cyc(1);
          lat++;
        end
      end
    join
    check("a5_latency", 32'(lat), 32'd155);
    check("a5_valid", 32'(valid), 32'd1);
    check("a5_data", 32'(data), 32'hA5);
    check("a5_no_ferr", 32'(ferr_cnt - ferr_base), 32'd0);
    check("a5_no_ovr", 32'(ovr_cnt - ovr_base), 32'd0);
    consume("a5_consume");
    cyc(10);

    // Glitch rejection then 0x3C
    vrise_base = vrise_cnt;
    rx = 1'b0;
    cyc(4);
    rx = 1'b1;
    cyc(30);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_novalid", 32'(vrise_cnt - vrise_base), 32'd0);
    send_frame(8'h3C, 1'b1);
    check("3c_valid", 32'(valid), 32'd1);
    check("3c_data", 32'(data), 32'h3C);
    consume("3c_consume");
    cyc(10);

    // Framing error: 0x55 with stop bit 0, line held low
    ferr_base  = ferr_cnt;
    vrise_base = vrise_cnt;
    send_frame(8'h55, 1'b0);
    cyc(40);
    check("ferr_pulse", 32'(ferr_cnt - ferr_base), 32'd1);
    check("ferr_novalid", 32'(valid), 32'd0);
    check("ferr_busy_low", 32'(busy), 32'd1);
    check("ferr_data_kept", 32'(data), 32'h3C);
    rx = 1'b1;
    cyc(4);
    check("ferr_busy_idle", 32'(busy), 32'd0);
    cyc(16);
    send_frame(8'h81, 1'b1);
    check("81_valid", 32'(valid), 32'd1);
    check("81_data", 32'(data), 32'h81);
    check("81_one_valid", 32'(vrise_cnt - vrise_base), 32'd1);
    consume("81_consume");
    cyc(10);

    // Overrun: back-to-back 0x11, 0x22 with ready low
    ovr_base = ovr_cnt;
    send_frame(8'h11, 1'b1);
    check("ovr_first_data", 32'(data), 32'h11);
    send_frame(8'h22, 1'b1);
    check("ovr_pulse", 32'(ovr_cnt - ovr_base), 32'd1);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_data_kept", 32'(data), 32'h11);
    consume("ovr_consume");
    cyc(10);

    // Mid-frame reset during data bit 3 of 0xF0, then 0x0F
    vrise_base = vrise_cnt;
    rx = 1'b0;
    cyc(16);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b0;
      cyc(16);
    end
    rx = 1'b0;
    cyc(8);
    rst_n = 1'b0;
    rx    = 1'b1;
    cyc(3);
    check("mrst_valid", 32'(valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_data", 32'(data), 32'h00);
    rst_n = 1'b1;
    cyc(40);
    check("mrst_idle_busy", 32'(busy), 32'd0);
    check("mrst_no_partial", 32'(vrise_cnt - vrise_base), 32'd0);
    send_frame(8'h0F, 1'b1);
    check("0f_valid", 32'(valid), 32'd1);
    check("0f_data", 32'(data), 32'h0F);
    check("0f_only_one", 32'(vrise_cnt - vrise_base), 32'd1);
    consume("0f_consume");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
